// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 size/sign codes
//   - response error codes
//   - FSM state encoding
//   - legality / alignment helper functions
package lsu_pkg;

  // funct3 codes (loads use all five, stores use the first three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size as carried in funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Response error codes
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_BUS      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // True when funct3 names a real RV32I load (we=0) or store (we=1).
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when a half/word access is not naturally aligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational data steering for the load/store unit.
//   Store side (driven from the incoming request):
//     req_size, req_addr_lo, req_wdata -> be (byte lanes), wdata_rep (lane-replicated data)
//   Load side (driven from the latched request):
//     rsp_funct3, rsp_addr_lo, rdata   -> rdata_ext (lane-selected, sign/zero-extended)
//   Misaligned offsets are truncated here (half ignores bit 0, word ignores
//   both bits); trapping, if enabled, happens before an access reaches here.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte enables and store-data replication for the outgoing access
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'd0;
    case (req_size)
      SZ_B: begin
        be        = 4'b0001 << req_addr_lo;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be        = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'd0;
      end
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    byte_lane = 8'd0;
    case (rsp_addr_lo)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      2'b11:   byte_lane = rdata[31:24];
      default: byte_lane = 8'd0;
    endcase
    half_lane = rsp_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = 32'd0;
    case (rsp_funct3[1:0])
      SZ_B: begin
        if (rsp_funct3[2]) begin
          rdata_ext = {24'd0, byte_lane};
        end else begin
          rdata_ext = {{24{byte_lane[7]}}, byte_lane};
        end
      end
      SZ_H: begin
        if (rsp_funct3[2]) begin
          rdata_ext = {16'd0, half_lane};
        end else begin
          rdata_ext = {{16{half_lane[15]}}, half_lane};
        end
      end
      SZ_W:    rdata_ext = rdata;
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory interface.
//   Takes one RV32I load/store at a time (req_*), issues a single word-addressed,
//   byte-strobed access (mem_*), and returns extended load data or an error
//   code as a one-cycle pulse (resp_*).
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     req_valid/ready/we/funct3/addr/wdata   request from execute
//     resp_valid/rdata/err/err_code          completion to writeback
//     mem_addr/be/wdata/rd_en/wr_en          memory command
//     mem_rdata/ack/err                      memory reply
//   Parameters: TIMEOUT_CYCLES (max WAIT cycles, 1..255), ADDR_W.
//   Build option: define MISALIGN_TRAP_EN to reject misaligned half/word
//   accesses with code 10; otherwise they are truncated and performed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [1:0]        resp_err_code,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic              mem_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  lsu_state_t  next_state;
  logic [7:0]  wait_cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic [1:0]  early_code;
  logic        ready_nxt;
  logic        valid_nxt;
  logic        rd_nxt;
  logic        wr_nxt;

  logic [3:0]  be_req;
  logic [31:0] wdata_req;
  logic [31:0] rdata_ext;

  assign accept = req_valid & req_ready;
  assign legal  = funct3_legal(req_we, req_funct3);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // An illegal funct3 outranks a misaligned address.
  assign early_code = legal ? ERR_MISALIGN : ERR_ILLEGAL;

  lsu_align u_align (
    .req_size    (req_funct3[1:0]),
    .req_addr_lo (req_addr[1:0]),
    .req_wdata   (req_wdata),
    .be          (be_req),
    .wdata_rep   (wdata_req),
    .rsp_funct3  (funct3_q),
    .rsp_addr_lo (addr_lo_q),
    .rdata       (mem_rdata),
    .rdata_ext   (rdata_ext)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!legal || misaligned) begin
            next_state = ST_RESP;
          end else begin
            next_state = ST_ISSUE;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        // An ack on the final allowed cycle still counts as a completion.
        if (mem_ack || (wait_cnt == TO_LAST)) begin
          next_state = ST_RESP;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode, one cycle ahead so the handshake outputs come from flops
  always_comb begin
    ready_nxt = (next_state == ST_IDLE);
    valid_nxt = (next_state == ST_RESP);
    if ((state == ST_IDLE) && (next_state == ST_ISSUE)) begin
      rd_nxt = ~req_we;
      wr_nxt = req_we;
    end else begin
      rd_nxt = 1'b0;
      wr_nxt = 1'b0;
    end
  end

  // Handshake and strobe output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
    end else begin
      req_ready  <= ready_nxt;
      resp_valid <= valid_nxt;
      mem_rd_en  <= rd_nxt;
      mem_wr_en  <= wr_nxt;
    end
  end

  // Request capture, memory command, wait counter and response payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      addr_lo_q     <= 2'd0;
      wait_cnt      <= 8'd0;
      mem_addr      <= '0;
      mem_be        <= 4'd0;
      mem_wdata     <= 32'd0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
      resp_err_code <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            if (next_state == ST_ISSUE) begin
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_req;
              mem_wdata <= wdata_req;
            end else begin
              resp_rdata    <= 32'd0;
              resp_err      <= 1'b1;
              resp_err_code <= early_code;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt <= 8'd0;
        end
        ST_WAIT: begin
          if (mem_ack) begin
            resp_rdata    <= (we_q || mem_err) ? 32'd0 : rdata_ext;
            resp_err      <= mem_err;
            resp_err_code <= mem_err ? ERR_BUS : ERR_NONE;
          end else if (wait_cnt == TO_LAST) begin
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b1;
            resp_err_code <= ERR_BUS;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          wait_cnt <= wait_cnt;
        end
        default: begin
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a vector table drives requests and
// plays the memory side; expected responses go into a scoreboard queue that a
// negedge monitor pops whenever resp_valid is seen.
module tb_load_store_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_err_code;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_err_code(resp_err_code),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;          // WAIT cycle carrying the ack, 0 = never ack
    logic        merr;
    logic        ack_issue;  // also raise a stray ack during ISSUE
    logic        exp_issue;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   resp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor and strobe bookkeeping
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_rd_en && mem_wr_en) begin
        total++; bad++;
        $display("FAIL both_strobes: rd=%0b wr=%0b", mem_rd_en, mem_wr_en);
      end
      if (mem_rd_en || mem_wr_en) strobe_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got rdata=0x%08h code=%0d, want no response", resp_rdata, resp_err_code);
        end else begin
          e = q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("resp_code", {30'd0, resp_err_code}, {30'd0, e.code});
          check("resp_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int   guard;
    int   st0;
    int   nwait;
    int   lat;
    exp_t e;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    check($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    nwait = (v.k == 0) ? TO : v.k;
    lat   = v.exp_issue ? (2 + nwait) : 1;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.code = v.exp_code; e.cyc = cyc + lat;
    q.push_back(e);
    st0 = strobe_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.exp_issue) begin
      check($sformatf("v%0d_rd_en", idx), {31'd0, mem_rd_en}, {31'd0, ~v.we});
      check($sformatf("v%0d_wr_en", idx), {31'd0, mem_wr_en}, {31'd0, v.we});
      check($sformatf("v%0d_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d_be", idx), {28'd0, mem_be}, {28'd0, v.exp_be});
      check($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata);
      mem_ack = v.ack_issue; mem_rdata = 32'h5EED_0BAD; mem_err = 1'b0;
      for (int j = 1; j <= nwait; j++) begin
        @(negedge clk);
        if (j == 1) check($sformatf("v%0d_wait_strobe", idx), {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        if (v.k != 0 && j == v.k) begin
          mem_ack = 1'b1; mem_rdata = v.rdata; mem_err = v.merr;
        end else begin
          mem_ack = 1'b0; mem_rdata = 32'h5EED_0BAD; mem_err = 1'b0;
        end
      end
      @(negedge clk);
      // After a timeout, a late ack must be ignored.
      mem_ack = (v.k == 0); mem_rdata = 32'hFFFF_FFFF; mem_err = 1'b0;
    end else begin
      check($sformatf("v%0d_no_strobe", idx), {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    end
    guard = 0;
    while (q.size() != 0 && guard < 30) begin @(negedge clk); guard++; end
    @(negedge clk);
    mem_ack = 1'b0; mem_err = 1'b0;
    check($sformatf("v%0d_resp_seen", idx), q.size(), 32'd0);
    check($sformatf("v%0d_strobes", idx), strobe_cnt - st0, {31'd0, v.exp_issue});
    if (v.exp_issue) check($sformatf("v%0d_be_hold", idx), {28'd0, mem_be}, {28'd0, v.exp_be});
    q.delete();
  endtask

  function automatic vec_t mk(
    input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rdata, input int k, input logic merr, input logic ack_issue,
    input logic exp_issue, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata, input logic exp_err, input logic [1:0] exp_code);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.k = k;
    v.merr = merr; v.ack_issue = ack_issue; v.exp_issue = exp_issue; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_code = exp_code;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int guard;
    int rc0;
    vec_t rv;
    // Table: we f3 addr wdata rdata k merr ack_issue | issue be wdata rdata err code
    vecs.push_back(mk(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 2'b00));
    vecs.push_back(mk(1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'b01));
    vecs.push_back(mk(1'b0, 3'b010, 32'h000, 32'h0, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h1234_5678, 1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_F000, 2, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0, 32'h0000_00F0, 1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 3'b001, 32'h002, 32'h0, 32'h8001_0000, 1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 3'b101, 32'h000, 32'h0, 32'h1234_ABCD, 1, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h0, 32'h0000_ABCD, 1'b0, 2'b00));
    vecs.push_back(mk(1'b1, 3'b000, 32'h001, 32'h0000_00A5, 32'h0, 2, 1'b0, 1'b0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 2'b00));
    vecs.push_back(mk(1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0, 1, 1'b0, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 3'b010, 32'h004, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1, 2'b11));
    vecs.push_back(mk(1'b1, 3'b100, 32'h000, 32'h0, 32'h0, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'b01));
    vecs.push_back(mk(1'b0, 3'b111, 32'h008, 32'h0, 32'h0, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'b01));
    vecs.push_back(mk(1'b0, 3'b010, 32'h020, 32'h0, 32'h55AA_55AA, 2, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0, 32'h55AA_55AA, 1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 3'b010, 32'h030, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1, 2'b11));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(1'b0, 3'b010, 32'h001, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'b10));
    vecs.push_back(mk(1'b0, 3'b001, 32'h003, 32'h0, 32'h7FFF_0001, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 3'b001, 32'h201, 32'h0000_1234, 32'h0, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 2'b10));
`else
    vecs.push_back(mk(1'b0, 3'b010, 32'h001, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 3'b001, 32'h003, 32'h0, 32'h7FFF_0001, 1, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h0, 32'h0000_7FFF, 1'b0, 2'b00));
    vecs.push_back(mk(1'b1, 3'b001, 32'h201, 32'h0000_1234, 32'h0, 1, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h1234_1234, 32'h0, 1'b0, 2'b00));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {29'd0, resp_err, resp_err_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset pulsed while the access sits in WAIT: the access is dropped silently.
    rc0 = resp_cnt;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_issue_rd", {31'd0, mem_rd_en}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    check("rstw_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rstw_no_resp", resp_cnt - rc0, 32'd0);
    check("rstw_ready_after", {31'd0, req_ready}, 32'd1);

    // Recovery: a normal access after the aborted one.
    rv = mk(1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_007F, 1, 1'b0, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h0000_007F, 1'b0, 2'b00);
    run_vec(rv, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
